// File: rtl/idu_pkg.sv
// Shared types and RV32I opcode constants for the instruction decode unit.
package idu_pkg;

    // Decoded operation class presented to the downstream stage.
    typedef enum logic [3:0] {
        OP_NONE     = 4'd0,
        OP_LUI      = 4'd1,
        OP_AUIPC    = 4'd2,
        OP_JAL      = 4'd3,
        OP_JALR     = 4'd4,
        OP_BRANCH   = 4'd5,
        OP_LOAD     = 4'd6,
        OP_STORE    = 4'd7,
        OP_OP_IMM   = 4'd8,
        OP_OP       = 4'd9,
        OP_MISC_MEM = 4'd10,
        OP_SYSTEM   = 4'd11,
        OP_ILLEGAL  = 4'd12
    } op_class_t;

    // Early-jump handshake state.
    typedef enum logic {
        IDLE = 1'b0,
        JREQ = 1'b1
    } state_t;

    // RV32I opcode[6:2] encodings.
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    // Map opcode[6:2] to an operation class; unknown encodings are illegal.
    function automatic op_class_t decode_op(input logic [4:0] opc);
        case (opc)
            OPC_LUI:      return OP_LUI;
            OPC_AUIPC:    return OP_AUIPC;
            OPC_JAL:      return OP_JAL;
            OPC_JALR:     return OP_JALR;
            OPC_BRANCH:   return OP_BRANCH;
            OPC_LOAD:     return OP_LOAD;
            OPC_STORE:    return OP_STORE;
            OPC_OP_IMM:   return OP_OP_IMM;
            OPC_OP:       return OP_OP;
            OPC_MISC_MEM: return OP_MISC_MEM;
            OPC_SYSTEM:   return OP_SYSTEM;
            default:      return OP_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/idu_imm_gen.sv
// Combinational immediate extraction: picks the I/S/B/U/J immediate for
// the operation class and sign-extends it to XLEN.
module imm_gen
    import idu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr_hi,
    input  op_class_t       op,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;

    // Assemble the 32-bit immediate for the instruction format of op.
    always_comb begin
        imm32 = '0;
        case (op)
            OP_JALR, OP_LOAD, OP_OP_IMM, OP_MISC_MEM, OP_SYSTEM:
                imm32 = {{21{instr_hi[31]}}, instr_hi[30:20]};
            OP_STORE:
                imm32 = {{21{instr_hi[31]}}, instr_hi[30:25], instr_hi[11:7]};
            OP_BRANCH:
                imm32 = {{20{instr_hi[31]}}, instr_hi[7], instr_hi[30:25],
                         instr_hi[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {instr_hi[31:12], 12'b0};
            OP_JAL:
                imm32 = {{12{instr_hi[31]}}, instr_hi[19:12], instr_hi[20],
                         instr_hi[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    // Signed cast widens with sign extension when XLEN exceeds 32.
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/idu.sv
// Instruction decode unit: registers decoded fields one cycle after
// capture and raises an early-jump request for every captured JAL.
module idu
    import idu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [31:2]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] inc_pc_in,
    input  logic            stall_in,
    input  logic            flush,
    output logic            ifu_stall,
    output logic            je,
    output logic [XLEN-1:0] ja,
    input  logic            jack,
    output logic            valid_out,
    output op_class_t       op,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic            funct7_5,
    output logic [XLEN-1:0] imm,
    output logic            illegal,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] inc_pc_out
);

    state_t          state_q;
    state_t          state_d;
    op_class_t       op_p0;
    logic [XLEN-1:0] imm_p0;
    logic            capture_p0;

    // ---- stage p0: combinational decode of the fetched word ----
    assign op_p0      = decode_op(instr_in[6:2]);
    assign ifu_stall  = stall_in | (state_q == JREQ);
    assign capture_p0 = valid_in & ~ifu_stall;
    assign je         = (state_q == JREQ);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_hi (instr_in[31:7]),
        .op       (op_p0),
        .imm      (imm_p0)
    );

    // Next-state logic: flush wins, a captured JAL requests, jack releases.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (capture_p0 && op_p0 == OP_JAL) state_d = JREQ;
                JREQ:    if (jack) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---- stage p1: decoded output register ----
    // Load on capture, hold under stall, drop valid otherwise; flush kills valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out  <= 1'b0;
            op         <= OP_NONE;
            rd         <= '0;
            rs1        <= '0;
            rs2        <= '0;
            funct3     <= '0;
            funct7_5   <= 1'b0;
            imm        <= '0;
            illegal    <= 1'b0;
            pc_out     <= '0;
            inc_pc_out <= '0;
        end else if (flush) begin
            valid_out  <= 1'b0;
        end else if (!stall_in) begin
            valid_out  <= capture_p0;
            if (capture_p0) begin
                op         <= op_p0;
                rd         <= instr_in[11:7];
                rs1        <= instr_in[19:15];
                rs2        <= instr_in[24:20];
                funct3     <= instr_in[14:12];
                funct7_5   <= instr_in[30];
                imm        <= imm_p0;
                illegal    <= (op_p0 == OP_ILLEGAL);
                pc_out     <= pc_in;
                inc_pc_out <= inc_pc_in;
            end
        end
    end

    // Jump target register, loaded only when a JAL enters JREQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ja <= '0;
        end else if (!flush && state_q == IDLE && capture_p0 && op_p0 == OP_JAL) begin
            ja <= pc_in + imm_p0;
        end
    end

endmodule

// File: tb/tb_idu.sv
// Self-checking bench for idu: directed scenarios followed by random traffic,
// compared against a behavioural model of the decode/jump rules.
module tb_idu;
    import idu_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, valid_in, stall_in, flush, jack;
    logic [31:2]     instr_in;
    logic [XLEN-1:0] pc_in, inc_pc_in;
    logic            ifu_stall, je, valid_out, funct7_5, illegal;
    logic [XLEN-1:0] ja, imm, pc_out, inc_pc_out;
    op_class_t       op;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;

    int checks = 0;
    int errors = 0;

    // Model state
    logic        m_vld, m_ill, m_f75, m_jp;
    op_class_t   m_op;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [2:0]  m_f3;
    logic [31:0] m_imm, m_pc, m_ipc, m_ja;

    always #5 clk = ~clk;

    idu #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .instr_in(instr_in),
        .pc_in(pc_in), .inc_pc_in(inc_pc_in), .stall_in(stall_in), .flush(flush),
        .ifu_stall(ifu_stall), .je(je), .ja(ja), .jack(jack),
        .valid_out(valid_out), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7_5(funct7_5), .imm(imm), .illegal(illegal),
        .pc_out(pc_out), .inc_pc_out(inc_pc_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic op_class_t ref_op(input logic [31:0] w);
        case (w[6:0])
            7'h37: return OP_LUI;
            7'h17: return OP_AUIPC;
            7'h6F: return OP_JAL;
            7'h67: return OP_JALR;
            7'h63: return OP_BRANCH;
            7'h03: return OP_LOAD;
            7'h23: return OP_STORE;
            7'h13: return OP_OP_IMM;
            7'h33: return OP_OP;
            7'h0F: return OP_MISC_MEM;
            7'h73: return OP_SYSTEM;
            default: return OP_ILLEGAL;
        endcase
    endfunction

    // Immediate value computed arithmetically from the field weights.
    function automatic logic [31:0] ref_imm(input logic [31:0] w, input op_class_t o);
        logic [31:0] v;
        v = 32'd0;
        case (o)
            OP_JALR, OP_LOAD, OP_OP_IMM, OP_MISC_MEM, OP_SYSTEM:
                v = w[30:20] - (w[31] ? 32'd2048 : 32'd0);
            OP_STORE:
                v = w[30:25] * 32'd32 + w[11:7] - (w[31] ? 32'd2048 : 32'd0);
            OP_BRANCH:
                v = w[7] * 32'd2048 + w[30:25] * 32'd32 + w[11:8] * 32'd2
                    - (w[31] ? 32'd4096 : 32'd0);
            OP_LUI, OP_AUIPC:
                v = w & 32'hFFFF_F000;
            OP_JAL:
                v = w[19:12] * 32'd4096 + w[20] * 32'd2048 + w[30:21] * 32'd2
                    - (w[31] ? 32'h0010_0000 : 32'd0);
            default:
                v = 32'd0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_vld = 0; m_ill = 0; m_f75 = 0; m_jp = 0; m_op = OP_NONE;
        m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_f3 = 0;
        m_imm = 0; m_pc = 0; m_ipc = 0; m_ja = 0;
    endtask

    task automatic compare_all();
        chk("valid_out", 32'(valid_out), 32'(m_vld));
        chk("op", 32'(op), 32'(m_op));
        chk("rd", 32'(rd), 32'(m_rd));
        chk("rs1", 32'(rs1), 32'(m_rs1));
        chk("rs2", 32'(rs2), 32'(m_rs2));
        chk("funct3", 32'(funct3), 32'(m_f3));
        chk("funct7_5", 32'(funct7_5), 32'(m_f75));
        chk("imm", imm, m_imm);
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("pc_out", pc_out, m_pc);
        chk("inc_pc_out", inc_pc_out, m_ipc);
        chk("je", 32'(je), 32'(m_jp));
        chk("ja", ja, m_ja);
    endtask

    // One clock: check ifu_stall, advance the model, step, compare outputs.
    task automatic tick();
        logic [31:0] w;
        logic        stall_m, cap;
        op_class_t   o;
        #1;
        w = {instr_in, 2'b11};
        stall_m = stall_in | m_jp;
        chk("ifu_stall", 32'(ifu_stall), 32'(stall_m));
        cap = valid_in & ~stall_m;
        o = ref_op(w);
        if (flush) begin
            m_vld = 0;
            m_jp  = 0;
        end else begin
            if (m_jp && jack) m_jp = 0;
            if (!stall_in) begin
                m_vld = cap;
                if (cap) begin
                    m_op = o; m_rd = w[11:7]; m_rs1 = w[19:15]; m_rs2 = w[24:20];
                    m_f3 = w[14:12]; m_f75 = w[30]; m_imm = ref_imm(w, o);
                    m_ill = (o == OP_ILLEGAL); m_pc = pc_in; m_ipc = inc_pc_in;
                    if (o == OP_JAL) begin
                        m_jp = 1;
                        m_ja = pc_in + ref_imm(w, o);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic present(input logic [31:0] w, input logic [31:0] pc);
        valid_in  = 1'b1;
        instr_in  = w[31:2];
        pc_in     = pc;
        inc_pc_in = pc + 32'd4;
    endtask

    logic [4:0] opcs [12];
    initial begin
        logic [31:0] r, w;
        opcs = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000, 5'b00000,
                 5'b01000, 5'b00100, 5'b01100, 5'b00011, 5'b11100, 5'b11111};
        reset = 1; valid_in = 0; stall_in = 0; flush = 0; jack = 0;
        instr_in = '0; pc_in = '0; inc_pc_in = '0;
        model_reset();
        #3;
        compare_all();
        @(posedge clk); #1;
        reset = 0;

        // ADDI x1,x0,5
        present(32'h0050_0093, 32'h40);
        tick();
        chk("addi_valid", 32'(valid_out), 32'd1);
        chk("addi_op", 32'(op), 32'(OP_OP_IMM));
        chk("addi_rd", 32'(rd), 32'd1);
        chk("addi_rs1", 32'(rs1), 32'd0);
        chk("addi_imm", imm, 32'h0000_0005);
        valid_in = 0;
        tick();
        chk("idle_valid", 32'(valid_out), 32'd0);

        // BEQ x0,x0,-8
        present(32'hFE00_0CE3, 32'h80);
        tick();
        chk("beq_op", 32'(op), 32'(OP_BRANCH));
        chk("beq_imm", imm, 32'hFFFF_FFF8);
        chk("beq_illegal", 32'(illegal), 32'd0);

        // Capture ADDI x3,x0,7 then stall for 4 cycles with new input offered
        present(32'h0070_0193, 32'hC0);
        tick();
        present(32'h0050_0093, 32'h200);
        stall_in = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_rd", 32'(rd), 32'd3);
            chk("stall_imm", imm, 32'd7);
            chk("stall_ifu", 32'(ifu_stall), 32'd1);
        end
        stall_in = 0; valid_in = 0;
        tick();

        // JAL x1,+16 at 0x100, jack during the third JREQ cycle
        present(32'h0100_00EF, 32'h100);
        tick();
        chk("jal_op", 32'(op), 32'(OP_JAL));
        chk("jal_ja", ja, 32'h110);
        for (int i = 0; i < 2; i++) begin
            chk("jreq_je", 32'(je), 32'd1);
            chk("jreq_ifu", 32'(ifu_stall), 32'd1);
            tick();
        end
        chk("jreq_je3", 32'(je), 32'd1);
        chk("jreq_ifu3", 32'(ifu_stall), 32'd1);
        jack = 1; valid_in = 0;
        tick();
        chk("jack_je", 32'(je), 32'd0);
        jack = 0;
        tick();

        // Flush in JREQ with jack in the same cycle
        present(32'h0100_00EF, 32'h300);
        tick();
        valid_in = 0; flush = 1; jack = 1;
        tick();
        chk("flush_je", 32'(je), 32'd0);
        chk("flush_valid", 32'(valid_out), 32'd0);
        flush = 0; jack = 0;
        tick();

        // Illegal opcode 0x7F
        present(32'h0000_007F, 32'h400);
        tick();
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_op", 32'(op), 32'(OP_ILLEGAL));

        // Async reset while a jump request is pending
        present(32'h0100_00EF, 32'h500);
        tick();
        chk("pre_rst_je", 32'(je), 32'd1);
        valid_in = 0;
        #2;
        reset = 1;
        #1;
        chk("async_rst_je", 32'(je), 32'd0);
        chk("async_rst_valid", 32'(valid_out), 32'd0);
        model_reset();
        compare_all();
        @(posedge clk); #1;
        reset = 0;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            w = {r[31:7], opcs[$urandom_range(0, 11)], 2'b11};
            if ($urandom_range(0, 9) == 0) w[6:2] = 5'($urandom());
            present(w, $urandom() & 32'hFFFF_FFFC);
            valid_in = ($urandom_range(0, 9) < 7);
            stall_in = ($urandom_range(0, 9) < 2);
            flush    = ($urandom_range(0, 19) == 0);
            jack     = ($urandom_range(0, 9) < 3);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
